// File: rtl/issue_if.sv
// Decoupled instruction channel shared by the decode->issue and issue->execute
// hops. The master drives valid and the payload; the slave returns ready.
// Payload: op, rs1, rs2, rd, imm, pc, and the operand values rs1_val/rs2_val.
// rs1_val and rs2_val carry data only on the issue->execute hop.
interface issue_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int RW = $clog2(NREG);

  logic            valid;
  logic            ready;
  logic [3:0]      op;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [RW-1:0]   rd;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  modport master (output valid, op, rs1, rs2, rd, imm, pc, rs1_val, rs2_val,
                  input  ready);
  modport slave  (input  valid, op, rs1, rs2, rd, imm, pc, rs1_val, rs2_val,
                  output ready);
endinterface

// File: rtl/issue.sv
// Single-entry issue stage: register file, scoreboard busy mask, hazard
// stall and one registered output slot toward execute.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   decoded         issue_if.slave  instruction from decode
//   issued          issue_if.master instruction plus operands to execute
//   wb_valid/wb_rd/wb_data  writeback from execute (cannot be back-pressured)
//   flush           discard the held, not-yet-accepted instruction
// Optional build macro ISSUE_BYPASS_EN: forward a same-cycle writeback into
// the captured operand and release the hazard in the writeback cycle.
// Op encoding: 0 INVAL, 8 BRANCH, 9 STORE do not write rd; all others do.
module issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  issue_if.slave                   decoded,
  issue_if.master                  issued,
  input  logic                     wb_valid,
  input  logic [$clog2(NREG)-1:0]  wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     flush
);
  localparam int RW = $clog2(NREG);
  localparam logic [3:0] OP_INVAL  = 4'd0;
  localparam logic [3:0] OP_BRANCH = 4'd8;
  localparam logic [3:0] OP_STORE  = 4'd9;

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy, busy_nxt;

  logic            out_valid;
  logic [3:0]      out_op;
  logic [RW-1:0]   out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0] out_imm, out_pc, out_rs1_val, out_rs2_val;

  logic            rs1_haz, rs2_haz, hazard, capture;
  logic [XLEN-1:0] rs1_opnd, rs2_opnd;

  function automatic logic writes_rd(input logic [3:0] op, input logic [RW-1:0] rd);
    return (rd != '0) && (op != OP_INVAL) && (op != OP_BRANCH) && (op != OP_STORE);
  endfunction

`ifdef ISSUE_BYPASS_EN
  logic rs1_fwd, rs2_fwd;
  assign rs1_fwd  = wb_valid && (wb_rd == decoded.rs1) && (decoded.rs1 != '0);
  assign rs2_fwd  = wb_valid && (wb_rd == decoded.rs2) && (decoded.rs2 != '0);
  assign rs1_haz  = (decoded.rs1 != '0) && busy[decoded.rs1] && !rs1_fwd;
  assign rs2_haz  = (decoded.rs2 != '0) && busy[decoded.rs2] && !rs2_fwd;
  assign rs1_opnd = rs1_fwd ? wb_data : rf[decoded.rs1];
  assign rs2_opnd = rs2_fwd ? wb_data : rf[decoded.rs2];
`else
  // Busy clears on the writeback edge, so the consumer reads the freshly
  // written register file one cycle after the writeback.
  assign rs1_haz  = (decoded.rs1 != '0) && busy[decoded.rs1];
  assign rs2_haz  = (decoded.rs2 != '0) && busy[decoded.rs2];
  assign rs1_opnd = rf[decoded.rs1];
  assign rs2_opnd = rf[decoded.rs2];
`endif

  assign hazard        = decoded.valid && (rs1_haz || rs2_haz);
  // rst term keeps ready low while reset is held, even though out_valid is 0.
  assign decoded.ready = rst && (!out_valid || issued.ready) && !hazard && !flush;
  assign capture       = decoded.valid && decoded.ready;

  // Clears first, capture set last so a same-edge set wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid)
      busy_nxt[wb_rd] = 1'b0;
    if (flush && out_valid && writes_rd(out_op, out_rd))
      busy_nxt[out_rd] = 1'b0;
    if (capture && writes_rd(decoded.op, decoded.rd))
      busy_nxt[decoded.rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_valid && (wb_rd != '0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= '0;
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
    end else begin
      busy <= busy_nxt;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid   <= 1'b1;
        out_op      <= decoded.op;
        out_rs1     <= decoded.rs1;
        out_rs2     <= decoded.rs2;
        out_rd      <= decoded.rd;
        out_imm     <= decoded.imm;
        out_pc      <= decoded.pc;
        out_rs1_val <= rs1_opnd;
        out_rs2_val <= rs2_opnd;
      end else if (issued.ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign issued.valid   = out_valid;
  assign issued.op      = out_op;
  assign issued.rs1     = out_rs1;
  assign issued.rs2     = out_rs2;
  assign issued.rd      = out_rd;
  assign issued.imm     = out_imm;
  assign issued.pc      = out_pc;
  assign issued.rs1_val = out_rs1_val;
  assign issued.rs2_val = out_rs2_val;
endmodule

// File: tb/tb_issue.sv
// Directed bench for the issue stage with hand-computed expectations.
module tb_issue;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam logic [3:0] ADD    = 4'd1;
  localparam logic [3:0] BRANCH = 4'd8;
`ifdef ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_valid, flush;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  int              n_checks = 0;
  int              n_pass   = 0;

  issue_if #(.XLEN(XLEN), .NREG(NREG)) decoded ();
  issue_if #(.XLEN(XLEN), .NREG(NREG)) issued ();

  issue #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .decoded(decoded), .issued(issued),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [XLEN-1:0] imm);
    decoded.valid = 1'b1;
    decoded.op    = op;
    decoded.rs1   = rs1;
    decoded.rs2   = rs2;
    decoded.rd    = rd;
    decoded.imm   = imm;
    decoded.pc    = imm + 32'h1000;
  endtask

  initial begin
    rst = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    decoded.rs1_val = '0; decoded.rs2_val = '0;
    issued.ready = 1'b0;
    present(ADD, 5'd0, 5'd0, 5'd2, 32'h0);
    #12;
    check("rst_out_valid", issued.valid, 0);
    check("rst_ready", decoded.ready, 0);
    check("rst_busy", dut.busy, 0);
    decoded.valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();

    // write x5 then read it
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    tick();
    wb_valid = 1'b0;
    present(ADD, 5'd5, 5'd0, 5'd1, 32'h0);
    #1 check("basic_ready", decoded.ready, 1);
    tick();
    decoded.valid = 1'b0;
    check("basic_valid", issued.valid, 1);
    check("basic_rs1", issued.rs1_val, 32'h1234);
    check("basic_rs2", issued.rs2_val, 0);
    check("basic_rd", issued.rd, 1);
    check("basic_pc", issued.pc, 32'h1000);
    check("basic_busy1", dut.busy[1], 1);
    issued.ready = 1'b1;
    tick();
    check("basic_drain", issued.valid, 0);

    // RAW hazard on x3, writeback four cycles after the producer issues
    present(ADD, 5'd0, 5'd0, 5'd3, 32'h0);
    tick();
    present(ADD, 5'd3, 5'd0, 5'd4, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      #1 check("raw_stall", decoded.ready, 0);
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hA;
    #1 check("raw_wb_cycle_ready", decoded.ready, BYP);
    tick();
    wb_valid = 1'b0;
    if (!BYP) begin
      check("raw_after_wb_ready", decoded.ready, 1);
      tick();
    end
    decoded.valid = 1'b0;
    check("raw_valid", issued.valid, 1);
    check("raw_rs1", issued.rs1_val, 32'hA);
    check("raw_rd", issued.rd, 4);
    tick();
    check("raw_drain", issued.valid, 0);

    // back-pressure hold for five cycles, then 1 per cycle
    issued.ready = 1'b0;
    present(ADD, 5'd0, 5'd0, 5'd8, 32'h11);
    tick();
    present(ADD, 5'd0, 5'd0, 5'd9, 32'h22);
    for (int c = 0; c < 5; c++) begin
      #1 check("hold_ready", decoded.ready, 0);
      check("hold_valid", issued.valid, 1);
      check("hold_imm", issued.imm, 32'h11);
      tick();
    end
    issued.ready = 1'b1;
    #1 check("release_ready", decoded.ready, 1);
    tick();
    check("b2b_imm2", issued.imm, 32'h22);
    present(ADD, 5'd0, 5'd0, 5'd10, 32'h33);
    #1 check("b2b_ready", decoded.ready, 1);
    tick();
    decoded.valid = 1'b0;
    check("b2b_imm3", issued.imm, 32'h33);
    check("b2b_valid3", issued.valid, 1);
    tick();
    check("b2b_drain", issued.valid, 0);

    // flush a held writer of x7, with a competing new instruction
    issued.ready = 1'b0;
    present(ADD, 5'd0, 5'd0, 5'd7, 32'h77);
    tick();
    check("flush_pre_busy7", dut.busy[7], 1);
    present(ADD, 5'd0, 5'd0, 5'd13, 32'h99);
    flush = 1'b1;
    #1 check("flush_ready", decoded.ready, 0);
    tick();
    flush = 1'b0;
    decoded.valid = 1'b0;
    check("flush_valid", issued.valid, 0);
    check("flush_busy7", dut.busy[7], 0);
    check("flush_busy13", dut.busy[13], 0);
    present(ADD, 5'd7, 5'd0, 5'd14, 32'h0);
    #1 check("flush_no_stall", decoded.ready, 1);
    tick();
    decoded.valid = 1'b0;
    issued.ready = 1'b1;
    tick();

    // x0 ignores writes, rd=0 and BRANCH never mark busy, set beats clear
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    tick();
    wb_valid = 1'b0;
    present(ADD, 5'd0, 5'd0, 5'd0, 32'h0);
    #1 check("x0_ready", decoded.ready, 1);
    tick();
    check("x0_rs1", issued.rs1_val, 0);
    check("x0_busy0", dut.busy[0], 0);
    present(ADD, 5'd0, 5'd0, 5'd15, 32'h0);
    #1 check("x0_consumer_ready", decoded.ready, 1);
    tick();
    present(BRANCH, 5'd0, 5'd0, 5'd6, 32'h0);
    tick();
    decoded.valid = 1'b0;
    check("branch_busy6", dut.busy[6], 0);
    present(ADD, 5'd0, 5'd0, 5'd11, 32'h0);
    wb_valid = 1'b1; wb_rd = 5'd11; wb_data = 32'h5;
    tick();
    wb_valid = 1'b0;
    decoded.valid = 1'b0;
    check("set_wins_busy11", dut.busy[11], 1);

    // async reset in the middle of a stall
    issued.ready = 1'b0;
    present(ADD, 5'd11, 5'd0, 5'd12, 32'h0);
    tick();
    check("pre_rst_stall", decoded.ready, 0);
    check("pre_rst_valid", issued.valid, 1);
    #3 rst = 1'b0;
    #1;
    check("async_rst_valid", issued.valid, 0);
    check("async_rst_busy", dut.busy, 0);
    check("async_rst_ready", decoded.ready, 0);
    decoded.valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    present(ADD, 5'd5, 5'd11, 5'd1, 32'h0);
    #1 check("post_rst_ready", decoded.ready, 1);
    tick();
    decoded.valid = 1'b0;
    check("post_rst_rf5", issued.rs1_val, 0);
    check("post_rst_valid", issued.valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/issue.md
ISSUE -- requirements
Module: issue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register and operand width.
REQ-002 SHALL have parameter NREG, default 32, meaning architectural register count; register index width is log2(NREG).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port decoded  decoupled.in  decoded_instr  instructions from decode; fields op, rs1, rs2, rd, imm, pc.
REQ-006 SHALL have port issued  decoupled.out  issued_instr  to execute; decoded_instr plus rs1_val, rs2_val (XLEN each).
REQ-007 SHALL have port wb_valid  input  1  writeback strobe from the unblockable execute result.
REQ-008 SHALL have port wb_rd  input  log2(NREG)  writeback destination index.
REQ-009 SHALL have port wb_data  input  XLEN  writeback value.
REQ-010 SHALL have port flush  input  1  discard the held, not-yet-accepted instruction.

Function
REQ-011 SHALL contain an NREG x XLEN register file; register 0 reads 0 and ignores writes.
REQ-012 SHALL write wb_data to entry wb_rd on the clock edge where wb_valid=1.
REQ-013 SHALL keep an NREG-bit busy mask: bit rd set when an instruction with rd!=0 and a writing op (not BRANCH, STORE, INVAL) is captured into the output register; bit cleared on wb_valid with matching wb_rd.
REQ-014 Set and clear of the same busy bit on the same edge: set SHALL win.
REQ-015 SHALL hold one output register (out_valid, out_data); issued.valid=out_valid, issued.data=out_data.
REQ-016 Hazard: decoded.valid with busy[rs1] or busy[rs2] set for a read source (rs!=0); register 0 is never busy.
REQ-017 decoded.ready SHALL be (!out_valid || issued.ready) && !hazard && !flush.
REQ-018 On decoded.valid && decoded.ready, SHALL capture the instruction and operands into the output register on that edge; issue latency is exactly 1 cycle.
REQ-019 When issued.ready && out_valid and no new capture, SHALL clear out_valid on the next edge.
REQ-020 Simultaneous accept downstream and capture upstream SHALL sustain one instruction per cycle.
REQ-021 SHALL keep out_data stable while out_valid && !issued.ready.
REQ-022 On flush, SHALL clear out_valid next edge and clear the busy bit set by the discarded entry, unless wb clears or re-sets it on the same edge; busy bits of instructions already in execute remain.
REQ-023 flush has priority over capture and over issued.ready in the same cycle.

Reset
REQ-024 While rst=0: out_valid=0, busy mask all 0, register file all 0, decoded.ready=0.
REQ-025 Reset asserted mid-transfer SHALL drop the held instruction with no partial writeback or busy state retained.

Configuration
REQ-026 With ISSUE_BYPASS_EN defined, a same-cycle wb_valid to rs1/rs2 SHALL clear that hazard and forward wb_data as the captured operand.
REQ-027 Without ISSUE_BYPASS_EN, operands SHALL be read only from the register file and the hazard SHALL persist until the cycle after writeback (one extra stall cycle).

Verification
REQ-028 Reset, write x5=0x1234 via wb, issue ADD rs1=5 rs2=0 -> issued.valid next cycle, rs1_val=0x1234, rs2_val=0.
REQ-029 Issue rd=3, then rs1=3 dependent; wb rd=3 data=0xA 4 cycles later -> dependent stalled (decoded.ready=0) until wb; captured rs1_val=0xA; stall ends in the wb cycle with bypass, one cycle later without.
REQ-030 issued.ready held 0 for 5 cycles with out_valid=1 -> out_data unchanged, decoded.ready=0; release -> back-to-back issue at 1 per cycle.
REQ-031 Flush while held entry has rd=7 and issued.ready=0 -> out_valid=0 next cycle, busy[7]=0, no instruction issued.
REQ-032 wb_valid rd=0 data=0xFFFF then read x0 -> rs1_val=0; instruction with rd=0 never stalls a consumer.
REQ-033 Assert rst=0 asynchronously mid-stall -> out_valid and busy mask 0 immediately without a clock edge.
